// File: rtl/rsv_station_if.sv
// Issue, wakeup and dispatch signals of the reservation station.
// The master side is the issue/writeback/dispatch environment; the slave side is the station.
interface rsv_station_if #(
   parameter int unsigned RSV_CAPACITY = 8,
   parameter int unsigned FUNC_CODE_W  = 6,
   parameter int unsigned FU_TYPE_W    = 3,
   parameter int unsigned VREG_IDX_W   = 6
);
   localparam int unsigned OCC_W = $clog2(RSV_CAPACITY) + 1;

   logic                                flush;
   logic                                inValid;
   logic                                inReady;
   logic [FUNC_CODE_W-1:0]              inOp;
   logic [FU_TYPE_W-1:0]                inFuType;
   logic [VREG_IDX_W-1:0]               inRa;
   logic [VREG_IDX_W-1:0]               inRb;
   logic [VREG_IDX_W-1:0]               inRc;
   logic [2:0]                          inSrcType;
   logic [2:0]                          inSrcRdy;
   logic [VREG_IDX_W-1:0]               inRd;
   logic                                inRdt;
   logic                                inRdValid;
   logic                                wbValid;
   logic [VREG_IDX_W-1:0]               wbReg;
   logic                                wbRegType;
   logic [RSV_CAPACITY-1:0]             dispatchAck;
   logic [RSV_CAPACITY-1:0]             opValid;
   logic [RSV_CAPACITY*FUNC_CODE_W-1:0] opIn;
   logic [RSV_CAPACITY*FU_TYPE_W-1:0]   funcUnitType;
   logic [RSV_CAPACITY*VREG_IDX_W-1:0]  ra;
   logic [RSV_CAPACITY*VREG_IDX_W-1:0]  rb;
   logic [RSV_CAPACITY*VREG_IDX_W-1:0]  rc;
   logic [RSV_CAPACITY*VREG_IDX_W-1:0]  rd;
   logic [RSV_CAPACITY-1:0]             rdt;
   logic [RSV_CAPACITY-1:0]             rdValid;
   logic [OCC_W-1:0]                    occupancy;

   modport master (
      output flush, inValid, inOp, inFuType, inRa, inRb, inRc, inSrcType, inSrcRdy,
             inRd, inRdt, inRdValid, wbValid, wbReg, wbRegType, dispatchAck,
      input  inReady, opValid, opIn, funcUnitType, ra, rb, rc, rd, rdt, rdValid, occupancy
   );

   modport slave (
      input  flush, inValid, inOp, inFuType, inRa, inRb, inRc, inSrcType, inSrcRdy,
             inRd, inRdt, inRdValid, wbValid, wbReg, wbRegType, dispatchAck,
      output inReady, opValid, opIn, funcUnitType, ra, rb, rc, rd, rdt, rdValid, occupancy
   );
endinterface

// File: rtl/rsv_station.sv
// Reservation station: holds renamed ops until all sources are woken, then
// offers them to the dispatchers and frees the slot on dispatch acknowledge.
module rsv_station #(
   parameter int unsigned RSV_CAPACITY = 8,
   parameter int unsigned FUNC_CODE_W  = 6,
   parameter int unsigned FU_TYPE_W    = 3,
   parameter int unsigned VREG_IDX_W   = 6
) (
   input logic          clk,
   input logic          rstn,
   rsv_station_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(RSV_CAPACITY);
   localparam int unsigned OCC_W = IDX_W + 1;

   logic [RSV_CAPACITY-1:0]                  busy, busyNext, ackEff, opValidC;
   logic [RSV_CAPACITY-1:0][2:0]             rdy, rdyNext, srcType;
   logic [RSV_CAPACITY-1:0][FUNC_CODE_W-1:0] opQ;
   logic [RSV_CAPACITY-1:0][FU_TYPE_W-1:0]   fuQ;
   logic [RSV_CAPACITY-1:0][VREG_IDX_W-1:0]  raQ, rbQ, rcQ, rdQ;
   logic [RSV_CAPACITY-1:0]                  rdtQ, rdValidQ;
   logic [OCC_W-1:0]                         occQ, ackCnt;
   logic [IDX_W-1:0]                         allocIdx;
   logic                                     anyFree, doAlloc;
   logic [2:0]                               inWake;

   // Lowest-index free slot, taken from pre-ack state.
   always_comb begin
      allocIdx = '0;
      anyFree  = 1'b0;
      for (int i = int'(RSV_CAPACITY) - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            allocIdx = IDX_W'(i);
            anyFree  = 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < int'(RSV_CAPACITY); i++) begin
         opValidC[i] = busy[i] & (&rdy[i]);
      end
   end

   assign doAlloc = bus.inValid & anyFree & ~bus.flush;

   // Next busy/ready state: wakeups, legal acks, allocation with same-cycle bypass, flush.
   always_comb begin
      inWake[0] = bus.wbValid && (bus.inRa == bus.wbReg) && (bus.inSrcType[0] == bus.wbRegType);
      inWake[1] = bus.wbValid && (bus.inRb == bus.wbReg) && (bus.inSrcType[1] == bus.wbRegType);
      inWake[2] = bus.wbValid && (bus.inRc == bus.wbReg) && (bus.inSrcType[2] == bus.wbRegType);
      ackEff    = bus.dispatchAck & opValidC;
      ackCnt    = '0;
      rdyNext   = rdy;
      for (int i = 0; i < int'(RSV_CAPACITY); i++) begin
         ackCnt = ackCnt + OCC_W'(ackEff[i]);
         if (busy[i] && bus.wbValid) begin
            if (raQ[i] == bus.wbReg && srcType[i][0] == bus.wbRegType) rdyNext[i][0] = 1'b1;
            if (rbQ[i] == bus.wbReg && srcType[i][1] == bus.wbRegType) rdyNext[i][1] = 1'b1;
            if (rcQ[i] == bus.wbReg && srcType[i][2] == bus.wbRegType) rdyNext[i][2] = 1'b1;
         end
      end
      busyNext = busy & ~ackEff;
      if (doAlloc) begin
         busyNext[allocIdx] = 1'b1;
         rdyNext[allocIdx]  = bus.inSrcRdy | inWake;
      end
      if (bus.flush) busyNext = '0;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         busy     <= '0;
         rdy      <= '0;
         srcType  <= '0;
         opQ      <= '0;
         fuQ      <= '0;
         raQ      <= '0;
         rbQ      <= '0;
         rcQ      <= '0;
         rdQ      <= '0;
         rdtQ     <= '0;
         rdValidQ <= '0;
         occQ     <= '0;
      end else begin
         busy <= busyNext;
         rdy  <= rdyNext;
         occQ <= bus.flush ? '0 : (occQ + OCC_W'(doAlloc) - ackCnt);
         if (doAlloc) begin
            srcType[allocIdx]  <= bus.inSrcType;
            opQ[allocIdx]      <= bus.inOp;
            fuQ[allocIdx]      <= bus.inFuType;
            raQ[allocIdx]      <= bus.inRa;
            rbQ[allocIdx]      <= bus.inRb;
            rcQ[allocIdx]      <= bus.inRc;
            rdQ[allocIdx]      <= bus.inRd;
            rdtQ[allocIdx]     <= bus.inRdt;
            rdValidQ[allocIdx] <= bus.inRdValid;
         end
      end
   end

   assign bus.inReady      = ~(&busy);
   assign bus.opValid      = opValidC;
   assign bus.opIn         = opQ;
   assign bus.funcUnitType = fuQ;
   assign bus.ra           = raQ;
   assign bus.rb           = rbQ;
   assign bus.rc           = rcQ;
   assign bus.rd           = rdQ;
   assign bus.rdt          = rdtQ;
   assign bus.rdValid      = rdValidQ;
   assign bus.occupancy    = occQ;
endmodule

// File: tb/tb_rsv_station.sv
// Directed bench for rsv_station (4 slots) with a slot-level reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_rsv_station;
   localparam int unsigned CAP = 4;
   localparam int unsigned FW  = 6;
   localparam int unsigned TW  = 3;
   localparam int unsigned VW  = 6;

   logic clk;
   logic rstn;
   int   total = 0;
   int   bad   = 0;

   rsv_station_if #(.RSV_CAPACITY(CAP), .FUNC_CODE_W(FW), .FU_TYPE_W(TW), .VREG_IDX_W(VW)) bus ();

   rsv_station #(.RSV_CAPACITY(CAP), .FUNC_CODE_W(FW), .FU_TYPE_W(TW), .VREG_IDX_W(VW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a set of slots with per-source readiness.
   logic           mInit = 1'b0;
   logic           mBusy [CAP];
   logic           mRdy  [CAP][3];
   logic           mType [CAP][3];
   logic [VW-1:0]  mSrc  [CAP][3];
   logic [FW-1:0]  mOp   [CAP];
   logic [TW-1:0]  mFu   [CAP];
   logic [VW-1:0]  mRd   [CAP];
   logic           mRdt  [CAP];
   logic           mRdv  [CAP];

   function automatic logic mReady(input int s);
      return mBusy[s] && mRdy[s][0] && mRdy[s][1] && mRdy[s][2];
   endfunction

   always @(posedge clk) begin
      logic          pv [CAP];
      logic [VW-1:0] inSrc [3];
      int            freeSlot;
      if (!rstn) begin
         mInit = 1'b1;
         for (int s = 0; s < int'(CAP); s++) begin
            mBusy[s] = 1'b0; mOp[s] = '0; mFu[s] = '0; mRd[s] = '0; mRdt[s] = 1'b0; mRdv[s] = 1'b0;
            for (int k = 0; k < 3; k++) begin
               mRdy[s][k] = 1'b0; mType[s][k] = 1'b0; mSrc[s][k] = '0;
            end
         end
      end else if (mInit) begin
         if (bus.dispatchAck != '0) begin
            logic [CAP-1:0] legal;
            for (int s = 0; s < int'(CAP); s++) legal[s] = mReady(s);
            chk("ack_on_ready_slot", 64'(bus.dispatchAck & ~legal), 64'd0);
         end
         if (bus.flush) begin
            for (int s = 0; s < int'(CAP); s++) mBusy[s] = 1'b0;
         end else begin
            freeSlot = -1;
            for (int s = 0; s < int'(CAP); s++) begin
               pv[s] = mReady(s);
               if (!mBusy[s] && freeSlot < 0) freeSlot = s;
            end
            for (int s = 0; s < int'(CAP); s++)
               if (mBusy[s] && bus.wbValid)
                  for (int k = 0; k < 3; k++)
                     if (mSrc[s][k] == bus.wbReg && mType[s][k] == bus.wbRegType) mRdy[s][k] = 1'b1;
            for (int s = 0; s < int'(CAP); s++)
               if (bus.dispatchAck[s] && pv[s]) mBusy[s] = 1'b0;
            if (bus.inValid && freeSlot >= 0) begin
               inSrc[0] = bus.inRa; inSrc[1] = bus.inRb; inSrc[2] = bus.inRc;
               mBusy[freeSlot] = 1'b1;
               mOp[freeSlot]   = bus.inOp;
               mFu[freeSlot]   = bus.inFuType;
               mRd[freeSlot]   = bus.inRd;
               mRdt[freeSlot]  = bus.inRdt;
               mRdv[freeSlot]  = bus.inRdValid;
               for (int k = 0; k < 3; k++) begin
                  mSrc[freeSlot][k]  = inSrc[k];
                  mType[freeSlot][k] = bus.inSrcType[k];
                  mRdy[freeSlot][k]  = bus.inSrcRdy[k] ||
                     (bus.wbValid && inSrc[k] == bus.wbReg && bus.inSrcType[k] == bus.wbRegType);
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (mInit) begin
         logic [63:0] eV, eOp, eFu, eA, eB, eC, eD, eDt, eDv;
         int          cnt;
         logic        anyFree;
         eV = '0; eOp = '0; eFu = '0; eA = '0; eB = '0; eC = '0; eD = '0; eDt = '0; eDv = '0;
         cnt = 0; anyFree = 1'b0;
         for (int s = 0; s < int'(CAP); s++) begin
            eV[s] = mReady(s);
            eOp[s*FW +: FW] = mOp[s];
            eFu[s*TW +: TW] = mFu[s];
            eA[s*VW +: VW] = mSrc[s][0];
            eB[s*VW +: VW] = mSrc[s][1];
            eC[s*VW +: VW] = mSrc[s][2];
            eD[s*VW +: VW] = mRd[s];
            eDt[s] = mRdt[s];
            eDv[s] = mRdv[s];
            if (mBusy[s]) cnt++; else anyFree = 1'b1;
         end
         chk("m_opValid", 64'(bus.opValid), eV);
         chk("m_inReady", 64'(bus.inReady), 64'(anyFree));
         chk("m_occupancy", 64'(bus.occupancy), 64'(cnt));
         chk("m_opIn", 64'(bus.opIn), eOp);
         chk("m_funcUnitType", 64'(bus.funcUnitType), eFu);
         chk("m_ra", 64'(bus.ra), eA);
         chk("m_rb", 64'(bus.rb), eB);
         chk("m_rc", 64'(bus.rc), eC);
         chk("m_rd", 64'(bus.rd), eD);
         chk("m_rdt", 64'(bus.rdt), eDt);
         chk("m_rdValid", 64'(bus.rdValid), eDv);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.flush = 1'b0; bus.inValid = 1'b0; bus.wbValid = 1'b0; bus.wbReg = '0;
      bus.wbRegType = 1'b0; bus.dispatchAck = '0;
   endtask

   task automatic setOp(input int opc, input int a, input int b, input int c,
                        input logic [2:0] st, input logic [2:0] sr);
      bus.inOp      = FW'(opc);
      bus.inFuType  = TW'(opc % 5);
      bus.inRa      = VW'(a);
      bus.inRb      = VW'(b);
      bus.inRc      = VW'(c);
      bus.inSrcType = st;
      bus.inSrcRdy  = sr;
      bus.inRd      = VW'(opc + 10);
      bus.inRdt     = opc[0];
      bus.inRdValid = 1'b1;
      bus.inValid   = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      idle();
      setOp(0, 0, 0, 0, 3'b000, 3'b111);
      bus.inValid = 1'b0;
      tick(); tick();
      rstn = 1'b1;
      chk("rst_opValid", 64'(bus.opValid), 64'd0);
      chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
      chk("rst_inReady", 64'(bus.inReady), 64'd1);
      chk("rst_opIn", 64'(bus.opIn), 64'd0);

      // Fill all four slots, then hold a fifth op
      for (int n = 0; n < 4; n++) begin
         setOp(n + 1, n, n + 1, n + 2, 3'b000, 3'b111);
         tick();
      end
      chk("fill_opValid", 64'(bus.opValid), 64'hf);
      chk("fill_occupancy", 64'(bus.occupancy), 64'd4);
      chk("fill_inReady", 64'(bus.inReady), 64'd0);
      for (int s = 0; s < 4; s++) chk("fill_slot_op", 64'(bus.opIn[s*FW +: FW]), 64'(s + 1));
      setOp(5, 7, 7, 7, 3'b000, 3'b111);
      tick();
      chk("held_occupancy", 64'(bus.occupancy), 64'd4);
      chk("held_slot3_op", 64'(bus.opIn[3*FW +: FW]), 64'd4);

      // Ack slot 2 while the fifth op waits; it lands one cycle later
      bus.dispatchAck = 4'b0100;
      tick();
      bus.dispatchAck = '0;
      chk("ack_opValid", 64'(bus.opValid), 64'hb);
      chk("ack_inReady", 64'(bus.inReady), 64'd1);
      chk("ack_occupancy", 64'(bus.occupancy), 64'd3);
      tick();
      bus.inValid = 1'b0;
      chk("reuse_occupancy", 64'(bus.occupancy), 64'd4);
      chk("reuse_slot2_op", 64'(bus.opIn[2*FW +: FW]), 64'd5);

      // Free slots 1 and 3, then ack slot 0 while allocating
      bus.dispatchAck = 4'b1010;
      tick();
      chk("free13_occupancy", 64'(bus.occupancy), 64'd2);
      bus.dispatchAck = 4'b0001;
      setOp(6, 1, 2, 3, 3'b000, 3'b111);
      tick();
      idle();
      chk("simul_opValid", 64'(bus.opValid), 64'h6);
      chk("simul_occupancy", 64'(bus.occupancy), 64'd2);
      chk("simul_slot1_op", 64'(bus.opIn[1*FW +: FW]), 64'd6);

      // Wakeup: source a = reg 5 type 1 not ready at issue
      setOp(8, 5, 0, 0, 3'b001, 3'b110);
      tick();
      idle();
      chk("wake_pre", 64'(bus.opValid[0]), 64'd0);
      bus.wbValid = 1'b1; bus.wbReg = 6'd5; bus.wbRegType = 1'b0;
      tick();
      chk("wake_wrong_type", 64'(bus.opValid[0]), 64'd0);
      bus.wbRegType = 1'b1;
      tick();
      idle();
      chk("wake_match", 64'(bus.opValid[0]), 64'd1);

      // Same-cycle bypass: source b = reg 9 type 1 written while allocating
      setOp(10, 0, 9, 0, 3'b010, 3'b101);
      bus.wbValid = 1'b1; bus.wbReg = 6'd9; bus.wbRegType = 1'b1;
      tick();
      idle();
      chk("bypass_opValid", 64'(bus.opValid), 64'hf);
      chk("bypass_occupancy", 64'(bus.occupancy), 64'd4);

      // Flush with three busy, an incoming op and an ack
      bus.dispatchAck = 4'b1000;
      tick();
      chk("preflush_occupancy", 64'(bus.occupancy), 64'd3);
      bus.dispatchAck = 4'b0001;
      bus.flush = 1'b1;
      setOp(7, 1, 1, 1, 3'b000, 3'b111);
      tick();
      idle();
      chk("flush_opValid", 64'(bus.opValid), 64'd0);
      chk("flush_occupancy", 64'(bus.occupancy), 64'd0);
      chk("flush_inReady", 64'(bus.inReady), 64'd1);
      chk("flush_slot0_op", 64'(bus.opIn[0 +: FW]), 64'd8);

      // Reset asserted mid-fill
      setOp(9, 2, 3, 4, 3'b000, 3'b111);
      tick(); tick();
      chk("midfill_occupancy", 64'(bus.occupancy), 64'd2);
      rstn = 1'b0;
      tick();
      chk("midrst_opValid", 64'(bus.opValid), 64'd0);
      chk("midrst_occupancy", 64'(bus.occupancy), 64'd0);
      chk("midrst_opIn", 64'(bus.opIn), 64'd0);
      chk("midrst_ra", 64'(bus.ra), 64'd0);
      rstn = 1'b1;
      idle();
      tick();
      chk("midrst_inReady", 64'(bus.inReady), 64'd1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
